// File: rtl/tec8_datapath_sequencer.sv
// TEC-8 execution side: beat sequencer, register file, ALU, PC/AR/IR,
// flags, RAM and panel bus, driven by the hardwired controller word.
module tec8_datapath_sequencer #(
  parameter int          MEM_AW = 8,
  parameter logic [7:0]  PC_RST = 8'h00
) (
  input  logic       T3,
  input  logic       CLR,
  input  logic       START,
  input  logic [7:0] SD,
  input  logic       SBUS,
  input  logic       MBUS,
  input  logic       ABUS,
  input  logic       SELCTL,
  input  logic       M,
  input  logic       CIN,
  input  logic       DRW,
  input  logic       LDZ,
  input  logic       LDC,
  input  logic       MEMW,
  input  logic       ARINC,
  input  logic       PCINC,
  input  logic       PCADD,
  input  logic       LPC,
  input  logic       LAR,
  input  logic       LIR,
  input  logic       STOP,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic [3:0] S,
  input  logic [3:0] SEL,
  output logic       W1,
  output logic       W2,
  output logic       W3,
  output logic [3:0] IR7_IR4,
  output logic       C,
  output logic       Z,
  output logic [7:0] DBUS,
  output logic [7:0] RA_OUT,
  output logic [7:0] RB_OUT,
  output logic [7:0] PC_OUT,
  output logic [7:0] AR_OUT,
  output logic [7:0] IR_OUT,
  output logic       HALTED,
  output logic       BUS_ERR
);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_W1,
    ST_W2,
    ST_W3
  } beat_t;

  beat_t state_q, state_d;
  beat_t resume_q, resume_d;
  beat_t next_beat;

  logic [7:0] rf [4];
  logic [7:0] mem [2**MEM_AW];
  logic [7:0] pc_q, ar_q, ir_q;
  logic       c_q, z_q, berr_q;

  logic       active;
  logic [1:0] a_sel, b_sel;
  logic [7:0] a_val, b_val;
  logic [7:0] alu_f, alu_y;
  logic       alu_co;
  logic [8:0] sum9;
  logic [7:0] mem_ar, mem_pc;
  logic       multi_src;

  // Beat sequencing: successor beat, STOP into HALT, START resumes
  always_comb begin
    next_beat = ST_W1;
    state_d   = state_q;
    resume_d  = resume_q;
    unique case (state_q)
      ST_W1:   next_beat = SHORT ? ST_W1 : ST_W2;
      ST_W2:   next_beat = LONG ? ST_W3 : ST_W1;
      ST_W3:   next_beat = ST_W1;
      default: next_beat = ST_W1;
    endcase
    if (state_q == ST_HALT) begin
      if (START) state_d = resume_q;
    end else if (STOP) begin
      state_d  = ST_HALT;
      resume_d = next_beat;
    end else begin
      state_d = next_beat;
    end
  end

  // Sequencer state registers
  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_HALT;
      resume_q <= ST_W1;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  assign active = (state_q != ST_HALT);
  assign W1     = (state_q == ST_W1);
  assign W2     = (state_q == ST_W2);
  assign W3     = (state_q == ST_W3);
  assign HALTED = (state_q == ST_HALT);

  assign a_sel  = SELCTL ? SEL[3:2] : ir_q[3:2];
  assign b_sel  = SELCTL ? SEL[1:0] : ir_q[1:0];
  assign a_val  = rf[a_sel];
  assign b_val  = rf[b_sel];
  assign mem_ar = mem[ar_q[MEM_AW-1:0]];
  assign mem_pc = mem[pc_q[MEM_AW-1:0]];

  // 74181-style ALU; CIN is active-low carry-in in arithmetic mode
  always_comb begin
    alu_f  = 8'h00;
    alu_co = 1'b0;
    alu_y  = 8'h00;
    sum9   = 9'h000;
    if (M) begin
      case (S)
        4'b1111: alu_f = a_val;
        4'b1010: alu_f = b_val;
        4'b1011: alu_f = a_val & b_val;
        4'b1110: alu_f = a_val | b_val;
        4'b0110: alu_f = a_val ^ b_val;
        4'b0000: alu_f = ~a_val;
        default: alu_f = 8'h00;
      endcase
    end else begin
      case (S)
        4'b1001: alu_y = b_val;
        4'b0110: alu_y = ~b_val;
        4'b1111: alu_y = 8'hFF;
        default: alu_y = 8'h00;
      endcase
      sum9   = {1'b0, a_val} + {1'b0, alu_y} + {8'h00, ~CIN};
      alu_f  = sum9[7:0];
      alu_co = sum9[8];
    end
  end

  assign DBUS = (SBUS ? SD : 8'h00) | (MBUS ? mem_ar : 8'h00)
              | (ABUS ? alu_f : 8'h00);
  assign multi_src = (SBUS & MBUS) | (SBUS & ABUS) | (MBUS & ABUS);

  // End-of-beat datapath register updates
  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      pc_q   <= PC_RST;
      ar_q   <= 8'h00;
      ir_q   <= 8'h00;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      berr_q <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (active) begin
      if (DRW) rf[a_sel] <= DBUS;
      if (LDC) c_q <= alu_co;
      if (LDZ) z_q <= (alu_f == 8'h00);
      if (multi_src) berr_q <= 1'b1;
      if (LPC) pc_q <= DBUS;
      else if (PCADD) pc_q <= pc_q + {{4{ir_q[3]}}, ir_q[3:0]};
      else if (PCINC) pc_q <= pc_q + 8'h01;
      if (LAR) ar_q <= DBUS;
      else if (ARINC) ar_q <= ar_q + 8'h01;
      if (LIR) ir_q <= mem_pc;
    end
  end

  // RAM write at pre-update AR; contents survive reset
  always_ff @(posedge T3) begin
    if (active && MEMW) mem[ar_q[MEM_AW-1:0]] <= DBUS;
  end

  assign RA_OUT  = a_val;
  assign RB_OUT  = b_val;
  assign PC_OUT  = pc_q;
  assign AR_OUT  = ar_q;
  assign IR_OUT  = ir_q;
  assign IR7_IR4 = ir_q[7:4];
  assign C       = c_q;
  assign Z       = z_q;
  assign BUS_ERR = berr_q;

endmodule

// File: doc/tec8_datapath_sequencer.md
Name: tec8_datapath_sequencer

Overview:
- Execution side of the hardwired controller. It consumes the controller's control word and produces the beat signals W1/W2/W3, the IR7_IR4 opcode field and the C/Z flags that the controller decodes.
- Contains the beat sequencer (SHORT/LONG/STOP handling), a 4x8 register file, a 74181-style ALU, PC, AR, IR, C/Z flags, a 256x8 RAM and the panel-switch bus source.
- Sits between the controller and the front-panel LEDs/switches.

Parameters:
- MEM_AW, 8, RAM address width (depth 2^MEM_AW, data 8 bits).
- PC_RST, 8'h00, PC value after reset.

Ports:
- T3  input  1  system clock; all state updates on rising edge.
- CLR  input  1  asynchronous active-high reset.
- START  input  1  panel start pulse (one cycle); leaves HALT.
- SD  input  8  panel data switches.
- SBUS, MBUS, ABUS, SELCTL, M, CIN, DRW, LDZ, LDC, MEMW, ARINC, PCINC, PCADD, LPC, LAR, LIR, STOP, SHORT, LONG  input  1 each  controller control signals.
- S  input  4  ALU function select.
- SEL  input  4  panel register select.
- W1, W2, W3  output  1 each  beat signals, one-hot or all zero.
- IR7_IR4  output  4  IR[7:4].
- C, Z  output  1 each  carry and zero flags.
- DBUS  output  8  current internal bus value.
- RA_OUT, RB_OUT  output  8 each  selected A/B register values for the LEDs.
- PC_OUT, AR_OUT, IR_OUT  output  8 each  register views.
- HALTED  output  1  sequencer is in HALT.
- BUS_ERR  output  1  sticky: more than one bus source was enabled in an active beat.

Behaviour:
- Reset (CLR=1, async): sequencer goes to HALT with resume beat W1. PC=PC_RST; AR, IR, R0..R3, C, Z and BUS_ERR are 0. RAM is not cleared. Reset asserted mid-beat aborts the beat with no write.
- Beat states: HALT, W1, W2, W3; each beat lasts one T3 cycle.
- Next beat:
  - W1 goes to W1 if SHORT, else W2.
  - W2 goes to W3 if LONG, else W1.
  - W3 goes to W1.
- If STOP=1 during a beat, the sequencer enters HALT at the end of that beat and stores the computed next beat. START in HALT resumes at the stored beat on the next cycle. START outside HALT is ignored.
- In HALT: W1=W2=W3=0 and no datapath state changes.
- Bus: DBUS = (SBUS?SD:0) | (MBUS?MEM[AR]:0) | (ABUS?F:0); 0 when no source is enabled. BUS_ERR sets if at least two sources are enabled in an active beat.
- Register addressing:
  - SELCTL=1: A/dest=SEL[3:2], B=SEL[1:0].
  - SELCTL=0: A/dest=IR[3:2], B=IR[1:0].
  - RA_OUT/RB_OUT are combinational reads.
- ALU, logic mode (M=1): S=1111 A; 1010 B; 1011 A&B; 1110 A|B; 0110 A^B; 0000 ~A; other codes 0x00. Carry-out is 0.
- ALU, arithmetic mode (M=0): 9-bit {co,F} = A + Y + c, with c = ~CIN (CIN is active-low).
  - Y: S=1001 B; 0110 ~B; 0000 0x00; 1111 0xFF; others 0x00.
  - Resulting operations: ADD A+B (CIN=1); SUB/CMP A−B (CIN=0, co=1 means no borrow); INC A+1 (CIN=0); DEC A−1 (CIN=1).
- End-of-beat updates (active beat only, all sampled together):
  - DRW: R[dest] ← DBUS.
  - LDC: C ← co.
  - LDZ: Z ← (F==0).
  - PC priority LPC > PCADD > PCINC: LPC gives PC ← DBUS; PCADD gives PC ← PC + sign-extended IR[3:0]; PCINC gives PC ← PC+1.
  - AR priority LAR > ARINC: LAR gives AR ← DBUS; ARINC gives AR ← AR+1.
  - MEMW: MEM[AR] ← DBUS, using the pre-update AR.
  - LIR: IR ← MEM[PC], using the pre-update PC.
- All arithmetic is modulo 256. PC and AR wrap 0xFF→0x00.

Test Plan:
- CLR pulse, then START → W1=1 one cycle later. Hold STOP=1 → HALTED=1 and W1/W2/W3=0 after that beat. Next START → W2=1.
- SHORT=1 in W1 → beats W1,W1. LONG=1 in W2 → beats W2,W3,W1. CLR asserted during W3 → immediate HALT, PC=0.
- SELCTL=1, SEL=1000, SBUS=1, SD=0x5A, DRW in W1 → R2=0x5A and RA_OUT=0x5A. Asserting SBUS+MBUS together → BUS_ERR=1 and it stays 1.
- R0=0xF0, R1=0x20, IR=0x01, ABUS, M=0, S=1001, CIN=1, DRW, LDC, LDZ in W2 → R0=0x10, C=1, Z=0. Then S=0110, CIN=0 with IR=0x00 → R0=0x00, Z=1, C=1.
- LAR with SD=0x10, then MEMW+ARINC with SBUS, SD=0x33 → MEM[0x10]=0x33, AR=0x11. Then LAR 0x10 and MBUS → DBUS=0x33.
- PC=0x10 (via LPC), LIR+PCINC in W1 → IR=0x33, IR7_IR4=0011, PC=0x11. PCADD in W2 → PC=0x14. PC=0xFF with PCINC → PC=0x00.
